// File: rtl/karplus_strong_poly.sv
// karplus_strong_poly: time-multiplexed polyphonic Karplus-Strong string synthesiser.
// Optional KS_POLY_STEREO_EN: even voices to o_q, odd voices to the added o_q_r port.
module karplus_strong_poly #(
    parameter int DATAWIDTH   = 16,
    parameter int DEPTHBITS   = 10,
    parameter int VOICEBITS   = 2,
    parameter int DECAY_SHIFT = 8
) (
    input  logic                        i_clk,
    input  logic                        i_reset_n,
    input  logic                        i_sample_ena,
    input  logic                        i_pluck,
    input  logic                        i_mute,
    input  logic [VOICEBITS-1:0]        i_voice,
    input  logic [DEPTHBITS-1:0]        i_pluck_len,
    input  logic [3:0]                  i_pluck_atten,
    output logic                        o_busy,
    output logic [(1<<VOICEBITS)-1:0]   o_active,
    output logic [DATAWIDTH-1:0]        o_q,
`ifdef KS_POLY_STEREO_EN
    output logic [DATAWIDTH-1:0]        o_q_r,
`endif
    output logic                        o_q_valid
);
    localparam int VOICES = 1 << VOICEBITS;
    localparam int AW     = DATAWIDTH + VOICEBITS;
    localparam logic [1:0] OP_NONE  = 2'd0;
    localparam logic [1:0] OP_PLUCK = 2'd1;
    localparam logic [1:0] OP_MUTE  = 2'd2;

    typedef enum logic [2:0] {S_IDLE, S_READ, S_CALC, S_WRITE, S_OUT} state_t;
    state_t r_state, w_next;

    logic [VOICEBITS-1:0]           r_v;
    logic [31:0]                    r_lfsr;
    logic [DATAWIDTH-1:0]           r_ram [VOICES << DEPTHBITS];
    logic [DATAWIDTH-1:0]           r_x, r_y, r_q;
    logic [DEPTHBITS-1:0]           r_ptr [VOICES];
    logic [DEPTHBITS-1:0]           r_len [VOICES];
    logic [DEPTHBITS-1:0]           r_burst [VOICES];
    logic [3:0]                     r_atten [VOICES];
    logic [DATAWIDTH-1:0]           r_prev [VOICES];
    logic [VOICES-1:0]              r_active;
    logic [1:0]                     r_pend_op [VOICES];
    logic [1:0]                     w_op [VOICES];
    logic [DEPTHBITS-1:0]           r_pend_len [VOICES];
    logic [DEPTHBITS-1:0]           w_len [VOICES];
    logic [3:0]                     r_pend_att [VOICES];
    logic [3:0]                     w_att [VOICES];
    logic signed [AW-1:0]           r_acc, w_acc, w_y_ext;
    logic                           w_start, w_last, w_wr;
    logic [VOICEBITS+DEPTHBITS-1:0] w_addr;
    logic signed [DATAWIDTH-1:0]    w_noise;
    logic signed [DATAWIDTH:0]      w_a;
    logic [DATAWIDTH-1:0]           w_y;

    assign w_start = i_sample_ena && r_state == S_IDLE;
    assign w_last  = r_v == VOICEBITS'(VOICES - 1);
    assign w_wr    = r_state == S_WRITE && r_active[r_v];
    assign w_addr  = {r_v, r_ptr[r_v]};
    assign w_noise = $signed(r_lfsr[31 -: DATAWIDTH]) >>> r_atten[r_v];
    assign w_a     = ($signed({r_x[DATAWIDTH-1], r_x}) +
                      $signed({r_prev[r_v][DATAWIDTH-1], r_prev[r_v]})) >>> 1;
    // A zero shift would cancel the sample entirely, so it means "no decay".
    assign w_y     = (r_burst[r_v] != '0) ? w_noise :
                     DATAWIDTH'(DECAY_SHIFT == 0 ? w_a : w_a - (w_a >>> DECAY_SHIFT));
    assign w_y_ext = {{VOICEBITS{r_y[DATAWIDTH-1]}}, r_y};
    assign o_active = r_active;
    assign o_q      = r_q;

    always_comb begin
        w_next    = r_state == S_IDLE  ? (i_sample_ena ? S_READ : S_IDLE) :
                    r_state == S_READ  ? S_CALC :
                    r_state == S_CALC  ? S_WRITE :
                    r_state == S_WRITE ? (w_last ? S_OUT : S_READ) : S_IDLE;
        o_busy    = r_state != S_IDLE;
        o_q_valid = r_state == S_OUT;
    end

    // Incoming command merged over the pending slot; mute beats a simultaneous pluck.
    always_comb begin
        for (int i = 0; i < VOICES; i++) begin
            w_op[i]  = r_pend_op[i];
            w_len[i] = r_pend_len[i];
            w_att[i] = r_pend_att[i];
            if ((i_pluck || i_mute) && i_voice == VOICEBITS'(i)) begin
                w_op[i]  = i_mute ? OP_MUTE : OP_PLUCK;
                w_len[i] = (i_pluck_len < DEPTHBITS'(2)) ? DEPTHBITS'(2) : i_pluck_len;
                w_att[i] = i_pluck_atten;
            end
        end
    end

`ifdef KS_POLY_STEREO_EN
    logic signed [AW-1:0] r_acc_r, w_acc_r;
    logic [DATAWIDTH-1:0] r_q_r;
    assign w_acc   = r_acc + ((w_wr && !r_v[0]) ? w_y_ext : '0);
    assign w_acc_r = r_acc_r + ((w_wr && r_v[0]) ? w_y_ext : '0);
    assign o_q_r   = r_q_r;
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_acc_r <= '0;
            r_q_r   <= '0;
        end else if (r_state == S_WRITE) begin
            r_acc_r <= w_last ? '0 : w_acc_r;
            if (w_last) r_q_r <= DATAWIDTH'(w_acc_r >>> (VOICEBITS - 1));
        end
    end
    localparam int OSH = VOICEBITS - 1;
`else
    assign w_acc = r_acc + (w_wr ? w_y_ext : '0);
    localparam int OSH = VOICEBITS;
`endif

    always_ff @(posedge i_clk) begin
        if (w_wr) r_ram[w_addr] <= r_y;
        if (r_state == S_READ) r_x <= r_ram[w_addr];
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state  <= S_IDLE;
            r_v      <= '0;
            r_lfsr   <= 32'hACE1_ACE1;
            r_y      <= '0;
            r_acc    <= '0;
            r_q      <= '0;
            r_active <= '0;
            for (int i = 0; i < VOICES; i++) begin
                r_ptr[i]      <= '0;
                r_len[i]      <= '0;
                r_burst[i]    <= '0;
                r_atten[i]    <= '0;
                r_prev[i]     <= '0;
                r_pend_op[i]  <= OP_NONE;
                r_pend_len[i] <= '0;
                r_pend_att[i] <= '0;
            end
        end else begin
            r_state <= w_next;
            if (r_state == S_CALC) r_y <= w_y;
            if (r_state == S_WRITE) begin
                r_v    <= r_v + 1'b1;
                r_lfsr <= {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? 32'h8020_0003 : 32'h0);
                r_acc  <= w_last ? '0 : w_acc;
                if (w_last) r_q <= DATAWIDTH'(w_acc >>> OSH);
            end
            for (int i = 0; i < VOICES; i++) begin
                r_pend_op[i]  <= w_start ? OP_NONE : w_op[i];
                r_pend_len[i] <= w_len[i];
                r_pend_att[i] <= w_att[i];
                if (w_start && w_op[i] == OP_PLUCK) begin
                    r_len[i]    <= w_len[i];
                    r_burst[i]  <= w_len[i];
                    r_atten[i]  <= w_att[i];
                    r_ptr[i]    <= '0;
                    r_prev[i]   <= '0;
                    r_active[i] <= 1'b1;
                end else if (w_start && w_op[i] == OP_MUTE) begin
                    r_active[i] <= 1'b0;
                end else if (w_wr && r_v == VOICEBITS'(i)) begin
                    r_prev[i] <= (r_burst[i] != '0) ? r_y : r_x;
                    if (r_burst[i] != '0) r_burst[i] <= r_burst[i] - 1'b1;
                    r_ptr[i]  <= (r_ptr[i] == r_len[i] - 1'b1) ? '0 : r_ptr[i] + 1'b1;
                end
            end
        end
    end
endmodule
